exc_ctrl: RTL

//  Exception/interrupt sequencer for the coprocessor 0 status state. Arbitrates

---
 rtl/exc_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates bus errors, decode errors and IRQs,
// drains and flushes the pipeline, saves EPC/IE and redirects fetch to the IVT.
module exc_ctrl #(
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_core_stall,
  input  logic                   i_dec_err,
  input  logic [ADDR_WIDTH-1:0]  i_dec_pc,
  input  logic                   i_bus_err,
  input  logic [ADDR_WIDTH-1:0]  i_bus_pc,
  input  logic [NIRQ-1:0]        i_irq,
  input  logic [ADDR_WIDTH-1:0]  i_next_pc,
  input  logic                   i_sr_ie,
  input  logic [ADDR_WIDTH-11:0] i_ivt,
  output logic                   o_flush,
  output logic                   o_epc_we,
  output logic [ADDR_WIDTH-1:0]  o_epc,
  output logic                   o_ie_save,
  output logic [3:0]             o_cause,
  output logic                   o_jump_valid,
  output logic [ADDR_WIDTH-1:0]  o_jump_addr,
  input  logic                   i_jump_ack,
  output logic                   o_busy
);

  localparam int unsigned CAUSE_W     = 4;
  localparam logic [CAUSE_W-1:0] CAUSE_DEC = 4'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_BUS = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_VECTOR
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   accept_c;
  logic [CAUSE_W-1:0]     evt_cause_c;
  logic [ADDR_WIDTH-1:0]  evt_pc_c;

  // Event arbitration: bus error > decode error > lowest-index enabled IRQ.
  always_comb begin
    accept_c    = 1'b0;
    evt_cause_c = '0;
    evt_pc_c    = '0;
    if (!i_core_stall) begin
      if (i_bus_err) begin
        accept_c    = 1'b1;
        evt_cause_c = CAUSE_BUS;
        evt_pc_c    = i_bus_pc;
      end else if (i_dec_err) begin
        accept_c    = 1'b1;
        evt_cause_c = CAUSE_DEC;
        evt_pc_c    = i_dec_pc;
      end else if (i_sr_ie) begin
        for (int n = 0; n < int'(NIRQ); n++) begin
          if (i_irq[n] && !accept_c) begin
            accept_c    = 1'b1;
            evt_cause_c = CAUSE_IRQ + CAUSE_W'(n);
            evt_pc_c    = i_next_pc;
          end
        end
      end
    end
  end

  // Next-state logic; new events are only considered in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_DRAIN;
      ST_DRAIN:  if (!i_core_stall) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_VECTOR;
      ST_VECTOR: if (i_jump_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs derived from the upcoming state; cause/EPC/vector latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_flush      <= 1'b0;
      o_epc_we     <= 1'b0;
      o_ie_save    <= 1'b0;
      o_jump_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_cause      <= '0;
      o_epc        <= '0;
      o_jump_addr  <= '0;
    end else begin
      o_flush      <= (state_d == ST_FLUSH);
      o_epc_we     <= (state_d == ST_FLUSH);
      o_ie_save    <= (state_d == ST_FLUSH);
      o_jump_valid <= (state_d == ST_VECTOR);
      o_busy       <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && accept_c) begin
        o_cause <= evt_cause_c;
        o_epc   <= evt_pc_c;
      end
      if (state_q == ST_FLUSH) begin
        o_jump_addr <= {i_ivt, o_cause, 6'b0};
      end
    end
  end

endmodule
